heartbeat_gen: RTL
==================

// Module: heartbeat_gen
// PURPOSE
//  uC-side transmitter of the watchdog heartbeat consumed by the board monitor.
//  Toggles 'watchdog' every HALF_PERIOD clocks while the application keeps checking in via 'alive'.
//  Missing check-ins stall the heartbeat so the monitor can flag the error.
//  The monitor's resetuC request drives a recovery sequence before the heartbeat restarts.
// PARAMETERS
//  CNT_W           24      width of contador
//  HALF_PERIOD     500000  clocks per heartbeat level (10 ms at 50 MHz); 2..2^CNT_W
//  CHECKIN_TIMEOUT 4       consecutive half-periods without alive before STALL; 1..15
//  RECOVER_CYCLES  1000    clocks watchdog is held low after resetuC falls; 1..2^CNT_W
// PORTS
//  clk       in   1      system clock
//  reset     in   1      synchronous, active-high reset
//  enable    in   1      1 = generate heartbeat
//  alive     in   1      application check-in; any-length pulse
//  resetuC   in   1      restart request from the monitor
//  watchdog  out  1      heartbeat line to the monitor
//  contador  out  CNT_W  current count (half-period or recovery)
//  stalled   out  1      1 while in STALL
//  state     out  2      IDLE=0, RUN=1, STALL=2, RECOVER=3
// BEHAVIOUR
//  All outputs are registered.
//  Reset values: state=IDLE, watchdog=0, contador=0, stalled=0; miss count=0, alive flag=0.
//  Priority per cycle: reset > resetuC > enable=0 > half-period boundary.
//  IDLE:
//   - watchdog=0, contador=0.
//   - enable=1 -> RUN next cycle with contador=0.
//  RUN:
//   - contador increments by 1 each clock.
//   - alive=1 sets a sticky seen flag.
//   - Boundary is contador==HALF_PERIOD-1. At the boundary, next cycle:
//     - contador=0 and the seen flag is cleared.
//     - seen (including alive on the boundary cycle itself) -> miss=0, watchdog toggles.
//     - not seen and miss+1<CHECKIN_TIMEOUT -> miss+=1, watchdog toggles.
//     - not seen and miss+1==CHECKIN_TIMEOUT -> STALL; watchdog does NOT toggle.
//   - enable=0 -> IDLE next cycle; watchdog=0, contador=0, miss=0.
//  STALL:
//   - watchdog holds its last level; contador=0; stalled=1.
//   - alive and enable are ignored; only resetuC or reset exits.
//  RECOVER:
//   - Entered next cycle when resetuC=1 in RUN or STALL.
//   - watchdog=0, stalled=0, miss=0.
//   - contador is held at 0 while resetuC=1.
//   - After resetuC falls, contador counts up to RECOVER_CYCLES-1, then:
//     - enable=1 -> RUN (contador=0).
//     - enable=0 -> IDLE.
//   - A new resetuC during the count restarts the count from 0.
//   - resetuC in IDLE is ignored.
//  contador never exceeds max(HALF_PERIOD, RECOVER_CYCLES)-1; no wrap-around.
//  Reset asserted in any state -> reset values on the next clock, including mid-RECOVER.
// TESTING (HALF_PERIOD=10, CHECKIN_TIMEOUT=3, RECOVER_CYCLES=5)
//  1. enable=1 at cycle E, alive pulse every 4 clocks
//     -> watchdog rises at E+11, then toggles every 10 clocks; stalled stays 0.
//  2. enable=1, alive never asserted
//     -> toggles at E+11 (to 1) and E+21 (to 0); state=STALL and stalled=1 at E+31;
//        watchdog held at 0.
//  3. From test 2, resetuC high for 3 clocks
//     -> RECOVER next cycle, stalled=0, watchdog=0;
//        RUN 5 clocks after resetuC falls; next rising edge 10 clocks later.
//  4. alive only on each boundary cycle (contador==9)
//     -> no STALL over 20 half-periods.
//     enable=0 mid-RUN -> IDLE, watchdog=0, contador=0 next clock.
//  5. reset pulse mid-RECOVER and mid-RUN with watchdog=1
//     -> state=0, watchdog=0, contador=0, stalled=0 next clock.
//     resetuC pulse in IDLE -> no state change.

Source files
------------

// File: rtl/heartbeat_gen.sv
// Watchdog heartbeat transmitter: toggles 'watchdog' every HALF_PERIOD clocks while 'alive' keeps checking in.
// Latency: every output is registered, so an input sampled on an edge is visible right after that edge.
// Backpressure: none; STALL holds the heartbeat until the monitor's resetuC runs a recovery sequence.
//
// Ports:
//   clk      in   1      system clock
//   reset    in   1      synchronous active-high reset
//   enable   in   1      1 = generate heartbeat
//   alive    in   1      application check-in pulse (any length)
//   resetuC  in   1      restart request from the board monitor
//   watchdog out  1      heartbeat line
//   contador out  CNT_W  current half-period or recovery count
//   stalled  out  1      1 while in STALL
//   state    out  2      IDLE=0, RUN=1, STALL=2, RECOVER=3
module heartbeat_gen #(
  parameter int unsigned CNT_W           = 24,
  parameter int unsigned HALF_PERIOD     = 500000,
  parameter int unsigned CHECKIN_TIMEOUT = 4,
  parameter int unsigned RECOVER_CYCLES  = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             alive,
  input  logic             resetuC,
  output logic             watchdog,
  output logic [CNT_W-1:0] contador,
  output logic             stalled,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STALL   = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HP_LAST  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] RC_LAST  = CNT_W'(RECOVER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // miss_q == TO_LAST means one more missed half-period reaches the timeout.
  localparam logic [3:0]       TO_LAST  = 4'(CHECKIN_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wd_q, wd_d;
  logic             stalled_q, stalled_d;
  logic [3:0]       miss_q, miss_d;
  logic             seen_q, seen_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wd_q      <= 1'b0;
      stalled_q <= 1'b0;
      miss_q    <= '0;
      seen_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      stalled_q <= stalled_d;
      miss_q    <= miss_d;
      seen_q    <= seen_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wd_d      = wd_q;
    stalled_d = stalled_q;
    miss_d    = miss_q;
    seen_d    = seen_q;

    case (state_q)
      ST_IDLE: begin
        // resetuC has no meaning here; only enable starts the heartbeat.
        cnt_d     = '0;
        wd_d      = 1'b0;
        stalled_d = 1'b0;
        miss_d    = '0;
        seen_d    = 1'b0;
        if (enable) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (resetuC) begin
          state_d   = ST_RECOVER;
          cnt_d     = '0;
          wd_d      = 1'b0;
          stalled_d = 1'b0;
          miss_d    = '0;
          seen_d    = 1'b0;
        end else if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          wd_d    = 1'b0;
          miss_d  = '0;
          seen_d  = 1'b0;
        end else if (cnt_q == HP_LAST) begin
          cnt_d  = '0;
          seen_d = 1'b0;
          // A check-in on the boundary cycle itself still counts for this half-period.
          if (seen_q || alive) begin
            miss_d = '0;
            wd_d   = ~wd_q;
          end else if (miss_q != TO_LAST) begin
            miss_d = miss_q + 4'd1;
            wd_d   = ~wd_q;
          end else begin
            // Timeout: freeze the line at its current level so the monitor sees no edge.
            state_d   = ST_STALL;
            stalled_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (alive) begin
            seen_d = 1'b1;
          end
        end
      end

      ST_STALL: begin
        cnt_d = '0;
        if (resetuC) begin
          state_d   = ST_RECOVER;
          wd_d      = 1'b0;
          stalled_d = 1'b0;
          miss_d    = '0;
          seen_d    = 1'b0;
        end
      end

      ST_RECOVER: begin
        wd_d      = 1'b0;
        stalled_d = 1'b0;
        miss_d    = '0;
        seen_d    = 1'b0;
        if (resetuC) begin
          // Count restarts for as long as the monitor keeps requesting.
          cnt_d = '0;
        end else if (cnt_q == RC_LAST) begin
          cnt_d   = '0;
          state_d = enable ? ST_RUN : ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        wd_d    = 1'b0;
      end
    endcase
  end

  assign watchdog = wd_q;
  assign contador = cnt_q;
  assign stalled  = stalled_q;
  assign state    = state_q;

endmodule
